// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage_pkg
//  Description : Shared types and constants for the MEM stage / MEM-WB
//                pipeline register: FSM state encoding, default widths,
//                timeout default and the all-zero reset word.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_stage_pkg;

    // Two-state access FSM, explicitly 1 bit wide
    typedef logic [0:0] state_t;

    localparam state_t c_ST_IDLE = 1'b0;
    localparam state_t c_ST_WAIT = 1'b1;

    localparam int c_DATA_W_DEF         = 32;
    localparam int c_REG_W_DEF          = 5;
    localparam int c_TIMEOUT_CYCLES_DEF = 255;

    localparam logic [c_DATA_W_DEF-1:0] c_WORD_ZERO = '0;

    // A store and a load request both count as a memory access
    function automatic logic f_is_access(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_timeout_counter
//  Description : Counts memory WAIT cycles without acknowledge. o_terminal
//                rises in the TIMEOUT_CYCLES-th counted cycle. Present only
//                when MEM_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef MEM_TIMEOUT_EN
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0] r_count;

    // Terminal when the current cycle is the last allowed un-acked one
    assign o_terminal = (r_count == c_CNT_W'(TIMEOUT_CYCLES - 1));

    // Cycle counter: cleared outside WAIT, saturates at the terminal value
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_terminal) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

endmodule
`endif
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : Memory-access stage plus MEM/WB pipeline register. Issues a
//                registered request to a variable-latency data memory,
//                stalls upstream while it is outstanding and registers the
//                write-back data, destination and write enable.
//                Optional feature: define MEM_TIMEOUT_EN to abort accesses
//                that see no acknowledge within TIMEOUT_CYCLES WAIT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W         = c_DATA_W_DEF,
    parameter int REG_W          = c_REG_W_DEF,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_write_in,
    input  logic              mem_read_in,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic [REG_W-1:0]  mux_reg_dst_out_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] mux_ALU_src_B_out_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_out,
    output logic              reg_write_out,
    output logic [REG_W-1:0]  wb_reg_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic              timeout_err_out
);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_access;
    logic                w_timeout;
    logic                w_stall;
    logic                r_dmem_req;
    logic                r_dmem_we;
    logic [DATA_W-1:0]   r_dmem_addr;
    logic [DATA_W-1:0]   r_dmem_wdata;
    logic                r_reg_write;
    logic [REG_W-1:0]    r_wb_reg;
    logic [DATA_W-1:0]   r_wb_data;

    assign w_access = f_is_access(mem_read_in, mem_write_in);

`ifdef MEM_TIMEOUT_EN
    logic w_terminal;
    logic r_timeout_err;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (r_state == c_ST_IDLE),
        .i_enable   ((r_state == c_ST_WAIT) && !dmem_ack),
        .o_terminal (w_terminal)
    );

    // An ack in the terminal cycle completes normally instead of aborting
    assign w_timeout = (r_state == c_ST_WAIT) && w_terminal && !dmem_ack;

    // One-cycle error pulse on the edge that aborts the access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
        end
    end

    assign timeout_err_out = r_timeout_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg    = ^TIMEOUT_CYCLES;
    assign w_timeout       = 1'b0;
    assign timeout_err_out = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: start on any access, finish on ack or abort
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_access)               w_state_next = c_ST_WAIT;
            default:   if (dmem_ack || w_timeout)  w_state_next = c_ST_IDLE;
        endcase
    end

    // Stall: never depends on read data, only on state, access and ack
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            c_ST_IDLE: w_stall = w_access;
            default:   w_stall = !(dmem_ack || w_timeout);
        endcase
    end

    assign stall_out = w_stall;

    // Memory port and MEM/WB register; a bubble only clears the write enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= DATA_W'(c_WORD_ZERO);
            r_dmem_wdata <= DATA_W'(c_WORD_ZERO);
            r_reg_write  <= 1'b0;
            r_wb_reg     <= '0;
            r_wb_data    <= DATA_W'(c_WORD_ZERO);
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_access) begin
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= mem_write_in;
                        r_dmem_addr  <= ALU_result_in;
                        r_dmem_wdata <= mux_ALU_src_B_out_in;
                        r_reg_write  <= 1'b0;
                    end else begin
                        r_reg_write  <= reg_write_in;
                        r_wb_reg     <= mux_reg_dst_out_in;
                        r_wb_data    <= ALU_result_in;
                    end
                end
                default: begin
                    if (dmem_ack) begin
                        r_dmem_req   <= 1'b0;
                        r_reg_write  <= reg_write_in;
                        r_wb_reg     <= mux_reg_dst_out_in;
                        r_wb_data    <= mem_to_reg_in ? dmem_rdata : ALU_result_in;
                    end else begin
                        r_reg_write  <= 1'b0;
                        if (w_timeout) begin
                            r_dmem_req <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign dmem_req      = r_dmem_req;
    assign dmem_we       = r_dmem_we;
    assign dmem_addr     = r_dmem_addr;
    assign dmem_wdata    = r_dmem_wdata;
    assign reg_write_out = r_reg_write;
    assign wb_reg_out    = r_wb_reg;
    assign wb_data_out   = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Self-checking bench for mem_wb_stage. Expected write-back,
//                stall counts and memory-port values come from a small
//                behavioural model of the stage's rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int TMO    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_write_in, mem_read_in, reg_write_in, mem_to_reg_in;
    logic [REG_W-1:0]  mux_reg_dst_out_in;
    logic [DATA_W-1:0] ALU_result_in, mux_ALU_src_B_out_in;
    logic              dmem_req, dmem_we, dmem_ack;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic              stall_out, reg_write_out, timeout_err_out;
    logic [REG_W-1:0]  wb_reg_out;
    logic [DATA_W-1:0] wb_data_out;

    int checks   = 0;
    int failures = 0;

    // Observations gathered by the memory-op driver
    int                obs_stalls, obs_req_cycles, obs_bubble_bad;
    logic              obs_stable, obs_req_idle, obs_req_after, obs_we, obs_rw;
    logic [DATA_W-1:0] obs_addr, obs_wdata, obs_data;
    logic [REG_W-1:0]  obs_reg;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .DATA_W         (DATA_W),
        .REG_W          (REG_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .mem_write_in         (mem_write_in),
        .mem_read_in          (mem_read_in),
        .reg_write_in         (reg_write_in),
        .mem_to_reg_in        (mem_to_reg_in),
        .mux_reg_dst_out_in   (mux_reg_dst_out_in),
        .ALU_result_in        (ALU_result_in),
        .mux_ALU_src_B_out_in (mux_ALU_src_B_out_in),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_wdata           (dmem_wdata),
        .dmem_ack             (dmem_ack),
        .dmem_rdata           (dmem_rdata),
        .stall_out            (stall_out),
        .reg_write_out        (reg_write_out),
        .wb_reg_out           (wb_reg_out),
        .wb_data_out          (wb_data_out),
        .timeout_err_out      (timeout_err_out)
    );

    // Reference: what the MEM/WB register holds after an instruction retires
    function automatic logic [1+REG_W+DATA_W-1:0] ref_wb(input logic is_mem, input logic m2r,
            input logic rw, input logic [REG_W-1:0] dst, input logic [DATA_W-1:0] alu,
            input logic [DATA_W-1:0] rdata);
        logic [DATA_W-1:0] d;
        d = (is_mem && m2r) ? rdata : alu;
        return {rw, dst, d};
    endfunction

    task automatic set_nop();
        mem_write_in = 1'b0; mem_read_in = 1'b0; reg_write_in = 1'b0; mem_to_reg_in = 1'b0;
        mux_reg_dst_out_in = '0; ALU_result_in = '0; mux_ALU_src_B_out_in = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
    endtask

    // Drives one memory instruction starting just after a rising edge; the
    // ack is given after wait_n un-acked WAIT cycles. Returns just after the
    // completing edge with the observations filled in.
    task automatic drive_mem_op(input logic wr, input logic rd, input logic m2r, input logic rw,
            input logic [REG_W-1:0] dst, input logic [DATA_W-1:0] addr,
            input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata, input int wait_n);
        mem_write_in = wr; mem_read_in = rd; mem_to_reg_in = m2r; reg_write_in = rw;
        mux_reg_dst_out_in = dst; ALU_result_in = addr; mux_ALU_src_B_out_in = wdata;
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        obs_stalls = 0; obs_req_cycles = 0; obs_bubble_bad = 0; obs_stable = 1'b1;
        @(negedge clk);
        if (stall_out) obs_stalls++;
        obs_req_idle = dmem_req;
        for (int k = 0; k <= wait_n; k++) begin
            @(posedge clk); #1;
            dmem_ack   = (k == wait_n);
            dmem_rdata = (k == wait_n) ? rdata : DATA_W'($urandom);
            @(negedge clk);
            if (stall_out) obs_stalls++;
            if (dmem_req) obs_req_cycles++;
            if (reg_write_out) obs_bubble_bad++;
            if (k == 0) begin
                obs_we = dmem_we; obs_addr = dmem_addr; obs_wdata = dmem_wdata;
            end else if (dmem_we !== obs_we || dmem_addr !== obs_addr || dmem_wdata !== obs_wdata) begin
                obs_stable = 1'b0;
            end
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        obs_req_after = dmem_req;
        obs_rw = reg_write_out; obs_reg = wb_reg_out; obs_data = wb_data_out;
    endtask

    task automatic idle_cycle();
        set_nop();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_nop();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, reg_write_out, wb_reg_out, wb_data_out, timeout_err_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got req=%0b we=%0b addr=%h wdata=%h rw=%0b reg=%0d data=%h err=%0b, expected all zero",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, reg_write_out, wb_reg_out, wb_data_out, timeout_err_out);
        end
        checks++;
        if (stall_out !== 1'b0) begin
            failures++; $display("FAIL reset_stall: got %0b expected 0", stall_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        logic [1+REG_W+DATA_W-1:0] exp_wb;
        int stalls;
        // Directed: dst 5, result 0x1234
        reg_write_in = 1'b1; mux_reg_dst_out_in = 5'd5; ALU_result_in = 32'h1234;
        @(negedge clk);
        checks++;
        if (stall_out !== 1'b0) begin
            failures++; $display("FAIL alu_stall: got %0b expected 0", stall_out);
        end
        @(posedge clk); #1;
        checks++;
        if ({reg_write_out, wb_reg_out, wb_data_out} !== {1'b1, 5'd5, 32'h1234}) begin
            failures++;
            $display("FAIL alu_wb: got rw=%0b reg=%0d data=%h expected rw=1 reg=5 data=00001234",
                     reg_write_out, wb_reg_out, wb_data_out);
        end
        // Random pass-through ops, with stray acks that must be ignored
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            reg_write_in = 1'($urandom); mem_to_reg_in = 1'($urandom);
            mux_reg_dst_out_in = REG_W'($urandom); ALU_result_in = $urandom;
            mux_ALU_src_B_out_in = $urandom; dmem_ack = 1'($urandom); dmem_rdata = $urandom;
            exp_wb = ref_wb(1'b0, mem_to_reg_in, reg_write_in, mux_reg_dst_out_in, ALU_result_in, dmem_rdata);
            @(negedge clk);
            if (stall_out) stalls++;
            @(posedge clk); #1;
            checks++;
            if ({reg_write_out, wb_reg_out, wb_data_out} !== exp_wb || dmem_req !== 1'b0) begin
                failures++;
                $display("FAIL alu_rand_wb: got %h req=%0b expected %h req=0",
                         {reg_write_out, wb_reg_out, wb_data_out}, dmem_req, exp_wb);
            end
        end
        checks++;
        if (stalls != 0) begin
            failures++; $display("FAIL alu_rand_stall: got %0d stall cycles expected 0", stalls);
        end
        idle_cycle();
    endtask

    task automatic test_load();
        drive_mem_op(1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h40, $urandom, 32'hDEADBEEF, 3);
        checks++;
        if (obs_stalls != 4) begin
            failures++; $display("FAIL load_stalls: got %0d expected 4", obs_stalls);
        end
        checks++;
        if (obs_req_cycles != 4 || obs_we !== 1'b0 || obs_addr !== 32'h40 || obs_stable !== 1'b1) begin
            failures++;
            $display("FAIL load_port: got req_cycles=%0d we=%0b addr=%h stable=%0b expected 4 0 00000040 1",
                     obs_req_cycles, obs_we, obs_addr, obs_stable);
        end
        checks++;
        if (obs_bubble_bad != 0) begin
            failures++; $display("FAIL load_bubble: got %0d write-enable cycles expected 0", obs_bubble_bad);
        end
        checks++;
        if ({obs_rw, obs_reg, obs_data} !== {1'b1, 5'd9, 32'hDEADBEEF} || obs_req_after !== 1'b0) begin
            failures++;
            $display("FAIL load_wb: got rw=%0b reg=%0d data=%h req=%0b expected 1 9 deadbeef 0",
                     obs_rw, obs_reg, obs_data, obs_req_after);
        end
        idle_cycle();
    endtask

    task automatic test_store();
        drive_mem_op(1'b1, 1'b0, 1'b0, 1'b0, REG_W'($urandom), 32'h80, 32'h55, $urandom, 1);
        checks++;
        if (obs_we !== 1'b1 || obs_addr !== 32'h80 || obs_wdata !== 32'h55) begin
            failures++;
            $display("FAIL store_port: got we=%0b addr=%h wdata=%h expected 1 00000080 00000055",
                     obs_we, obs_addr, obs_wdata);
        end
        checks++;
        if (obs_rw !== 1'b0 || obs_req_after !== 1'b0 || obs_stalls != 2) begin
            failures++;
            $display("FAIL store_done: got rw=%0b req=%0b stalls=%0d expected 0 0 2",
                     obs_rw, obs_req_after, obs_stalls);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [1+REG_W+DATA_W-1:0] exp_q[$];
        logic [1+REG_W+DATA_W-1:0] exp_wb;
        logic [DATA_W-1:0] a, r;
        logic [REG_W-1:0]  d;
        for (int i = 0; i < 2; i++) begin
            a = $urandom; r = $urandom; d = REG_W'(i + 11);
            exp_q.push_back(ref_wb(1'b1, 1'b1, 1'b1, d, a, r));
            drive_mem_op(1'b0, 1'b1, 1'b1, 1'b1, d, a, $urandom, r, 0);
            exp_wb = exp_q.pop_front();
            checks++;
            if (obs_stalls != 1 || obs_req_idle !== 1'b0) begin
                failures++;
                $display("FAIL b2b_stall_%0d: got stalls=%0d req_between=%0b expected 1 0", i, obs_stalls, obs_req_idle);
            end
            checks++;
            if ({obs_rw, obs_reg, obs_data} !== exp_wb) begin
                failures++;
                $display("FAIL b2b_wb_%0d: got %h expected %h", i, {obs_rw, obs_reg, obs_data}, exp_wb);
            end
        end
        idle_cycle();
    endtask

    task automatic test_reset_in_wait();
        mem_read_in = 1'b1; mem_to_reg_in = 1'b1; reg_write_in = 1'b1;
        mux_reg_dst_out_in = 5'd3; ALU_result_in = 32'h100; mux_ALU_src_B_out_in = 32'hAAAA;
        @(posedge clk); #1;
        checks++;
        if (dmem_req !== 1'b1) begin
            failures++; $display("FAIL rstwait_req: got %0b expected 1", dmem_req);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, reg_write_out, wb_reg_out, wb_data_out, timeout_err_out} !== '0) begin
            failures++;
            $display("FAIL rstwait_outputs: got req=%0b addr=%h rw=%0b data=%h expected all zero",
                     dmem_req, dmem_addr, reg_write_out, wb_data_out);
        end
        // Stray ack while back in IDLE with the load still presented
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        checks++;
        if (stall_out !== 1'b1) begin
            failures++; $display("FAIL rstwait_stray_stall: got %0b expected 1", stall_out);
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        checks++;
        if (reg_write_out !== 1'b0 || dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL rstwait_stray_wb: got rw=%0b req=%0b expected rw=0 req=1", reg_write_out, dmem_req);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h77;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        checks++;
        if ({reg_write_out, wb_reg_out, wb_data_out} !== {1'b1, 5'd3, 32'h77}) begin
            failures++;
            $display("FAIL rstwait_retry_wb: got rw=%0b reg=%0d data=%h expected 1 3 00000077",
                     reg_write_out, wb_reg_out, wb_data_out);
        end
        idle_cycle();
    endtask

    task automatic test_timeout();
        int stalls;
        int errs;
        mem_read_in = 1'b1; mem_to_reg_in = 1'b1; reg_write_in = 1'b1;
        mux_reg_dst_out_in = 5'd7; ALU_result_in = 32'h200;
        stalls = 0; errs = 0;
        @(negedge clk);
        if (stall_out) stalls++;
`ifdef MEM_TIMEOUT_EN
        for (int k = 0; k < TMO; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (stall_out) stalls++;
        end
        @(posedge clk); #1;
        set_nop();
        checks++;
        if (stalls != TMO) begin
            failures++; $display("FAIL timeout_stalls: got %0d expected %0d", stalls, TMO);
        end
        checks++;
        if (timeout_err_out !== 1'b1 || reg_write_out !== 1'b0 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL timeout_abort: got err=%0b rw=%0b req=%0b expected 1 0 0",
                     timeout_err_out, reg_write_out, dmem_req);
        end
        @(posedge clk); #1;
        checks++;
        if (timeout_err_out !== 1'b0 || stall_out !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse: got err=%0b stall=%0b expected 0 0", timeout_err_out, stall_out);
        end
`else
        for (int k = 0; k < 3 * TMO; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (stall_out) stalls++;
            if (timeout_err_out) errs++;
        end
        checks++;
        if (stalls != 3 * TMO + 1 || errs != 0 || dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL long_wait: got stalls=%0d errs=%0d req=%0b expected %0d 0 1",
                     stalls, errs, dmem_req, 3 * TMO + 1);
        end
        #1;
        dmem_ack = 1'b1; dmem_rdata = 32'h1357;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        checks++;
        if ({reg_write_out, wb_reg_out, wb_data_out} !== {1'b1, 5'd7, 32'h1357}) begin
            failures++;
            $display("FAIL long_wait_wb: got rw=%0b reg=%0d data=%h expected 1 7 00001357",
                     reg_write_out, wb_reg_out, wb_data_out);
        end
`endif
        idle_cycle();
    endtask

    task automatic test_random();
        logic [1+REG_W+DATA_W-1:0] exp_wb;
        logic wr, rd, m2r, rw;
        logic [REG_W-1:0]  d;
        logic [DATA_W-1:0] a, wd, r;
        int kind, wn;
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 3);
            wn   = $urandom_range(0, 3);
            m2r = 1'($urandom); rw = 1'($urandom); d = REG_W'($urandom);
            a = $urandom; wd = $urandom; r = $urandom;
            wr = (kind == 2 || kind == 3);
            rd = (kind == 1 || kind == 3);
            if (kind == 0) begin
                mem_write_in = 1'b0; mem_read_in = 1'b0; mem_to_reg_in = m2r; reg_write_in = rw;
                mux_reg_dst_out_in = d; ALU_result_in = a; mux_ALU_src_B_out_in = wd;
                dmem_ack = 1'($urandom); dmem_rdata = r;
                exp_wb = ref_wb(1'b0, m2r, rw, d, a, r);
                @(negedge clk);
                checks++;
                if (stall_out !== 1'b0) begin
                    failures++; $display("FAIL rand_alu_stall_%0d: got %0b expected 0", i, stall_out);
                end
                @(posedge clk); #1;
                dmem_ack = 1'b0;
                checks++;
                if ({reg_write_out, wb_reg_out, wb_data_out} !== exp_wb) begin
                    failures++;
                    $display("FAIL rand_alu_wb_%0d: got %h expected %h", i, {reg_write_out, wb_reg_out, wb_data_out}, exp_wb);
                end
            end else begin
                exp_wb = ref_wb(1'b1, m2r, rw, d, a, r);
                drive_mem_op(wr, rd, m2r, rw, d, a, wd, r, wn);
                checks++;
                if (obs_stalls != wn + 1 || obs_req_cycles != wn + 1 || obs_req_idle !== 1'b0 || obs_req_after !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_mem_timing_%0d: got stalls=%0d req_cycles=%0d req_idle=%0b req_after=%0b expected %0d %0d 0 0",
                             i, obs_stalls, obs_req_cycles, obs_req_idle, obs_req_after, wn + 1, wn + 1);
                end
                checks++;
                if (obs_we !== wr || obs_addr !== a || (wr && obs_wdata !== wd) || obs_stable !== 1'b1 || obs_bubble_bad != 0) begin
                    failures++;
                    $display("FAIL rand_mem_port_%0d: got we=%0b addr=%h wdata=%h stable=%0b bubbles_bad=%0d expected we=%0b addr=%h wdata=%h",
                             i, obs_we, obs_addr, obs_wdata, obs_stable, obs_bubble_bad, wr, a, wd);
                end
                checks++;
                if ({obs_rw, obs_reg, obs_data} !== exp_wb) begin
                    failures++;
                    $display("FAIL rand_mem_wb_%0d: got %h expected %h", i, {obs_rw, obs_reg, obs_data}, exp_wb);
                end
            end
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_in_wait();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so a stuck run still ends
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
